// File: rtl/baccarat_pkg.sv
// Definitions shared by the round controller, the card state machine and the datapath.
// Bet and result encodings line up, so a winning side bet equals its result code.
package baccarat_pkg;

  typedef enum logic [1:0] {
    BET_NONE   = 2'b00,
    BET_PLAYER = 2'b01,
    BET_DEALER = 2'b10,
    BET_TIE    = 2'b11
  } bet_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'b00,
    RES_PLAYER = 2'b01,
    RES_DEALER = 2'b10,
    RES_TIE    = 2'b11
  } result_t;

  typedef enum logic [2:0] {
    WC_BET    = 3'd0,
    WC_LOCK   = 3'd1,
    WC_DEAL   = 3'd2,
    WC_SETTLE = 3'd3,
    WC_SHOW   = 3'd4,
    WC_BROKE  = 3'd5
  } wc_state_t;

endpackage

// File: rtl/payout_calc.sv
// Combinational payout: credit owed for an escrowed wager given the bet and the dealt result.
// The credit is WIDTH+4 bits wide so a tie payout of up to 15x the wager cannot overflow.
module payout_calc
  import baccarat_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TIE_PAYOUT = 8
) (
  input  logic [1:0]       bet_q,
  input  logic [1:0]       result_q,
  input  logic [WIDTH-1:0] wager_q,
  output logic [WIDTH+3:0] credit
);

  localparam int CW = WIDTH + 4;

  logic [CW-1:0] wager_ext;
  logic [CW-1:0] tie_mult;

  assign wager_ext = CW'(wager_q);
  assign tie_mult  = CW'(TIE_PAYOUT + 1);

  always_comb begin
    credit = '0;
    if (result_q == RES_NONE) begin
      // No outcome from the deal: refund the stake.
      credit = wager_ext;
    end else if (result_q == RES_TIE) begin
      if (bet_q == BET_TIE) begin
        credit = tie_mult * wager_ext;
      end else begin
        credit = wager_ext;
      end
    end else if (bet_q == result_q) begin
      credit = wager_ext << 1;
    end
  end

endmodule

// File: rtl/wager_controller.sv
// Round controller: owns the balance and walks BET -> LOCK -> DEAL -> SETTLE -> SHOW each round.
// Wager is escrowed on the accepting BET edge, debited in LOCK and paid out in SETTLE.
module wager_controller
  import baccarat_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] INIT_BALANCE = WIDTH'(100),
  parameter int               TIE_PAYOUT   = 8
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] wager_in,
  input  logic [1:0]       bet_in,
  input  logic             round_done,
  input  logic [1:0]       result,
  output logic             betting,
  output logic             load_wager,
  output logic             start_deal,
  output logic [WIDTH-1:0] balance,
  output logic             reject,
  output logic             broke
);

  wc_state_t        state;
  wc_state_t        state_next;
  logic [WIDTH-1:0] wager_q;
  bet_t             bet_q;
  result_t          result_q;
  logic             deal_started;
  logic             bet_ok;
  logic [WIDTH+3:0] credit;
  logic [WIDTH+4:0] credit_sum;
  logic [WIDTH-1:0] balance_settled;

  assign bet_ok = (bet_in != BET_NONE) && (wager_in != '0) && (wager_in <= balance);

  payout_calc #(
    .WIDTH      (WIDTH),
    .TIE_PAYOUT (TIE_PAYOUT)
  ) u_payout (
    .bet_q    (bet_q),
    .result_q (result_q),
    .wager_q  (wager_q),
    .credit   (credit)
  );

  // Saturate the credited balance at the top of the WIDTH-bit range.
  assign credit_sum      = {5'b0, balance} + {1'b0, credit};
  assign balance_settled = (credit_sum[WIDTH+4:WIDTH] != '0) ? {WIDTH{1'b1}}
                                                             : credit_sum[WIDTH-1:0];

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state <= WC_BET;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    betting    = 1'b0;
    load_wager = 1'b0;
    start_deal = 1'b0;
    broke      = 1'b0;
    case (state)
      WC_BET: begin
        betting = 1'b1;
        if (bet_ok) begin
          state_next = WC_LOCK;
        end
      end
      WC_LOCK: begin
        load_wager = 1'b1;
        state_next = WC_DEAL;
      end
      WC_DEAL: begin
        start_deal = !deal_started;
        if (round_done) begin
          state_next = WC_SETTLE;
        end
      end
      WC_SETTLE: begin
        state_next = WC_SHOW;
      end
      WC_SHOW: begin
        state_next = (balance == '0) ? WC_BROKE : WC_BET;
      end
      WC_BROKE: begin
        broke = 1'b1;
      end
      default: begin
        state_next = WC_BET;
      end
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      balance      <= INIT_BALANCE;
      wager_q      <= '0;
      bet_q        <= BET_NONE;
      result_q     <= RES_NONE;
      reject       <= 1'b0;
      deal_started <= 1'b0;
    end else begin
      case (state)
        WC_BET: begin
          reject <= !bet_ok;
          if (bet_ok) begin
            wager_q <= wager_in;
            bet_q   <= bet_t'(bet_in);
          end
        end
        WC_LOCK: begin
          // Cannot underflow: the BET check guaranteed wager_q <= balance.
          balance      <= balance - wager_q;
          deal_started <= 1'b0;
        end
        WC_DEAL: begin
          deal_started <= 1'b1;
          if (round_done) begin
            result_q <= result_t'(result);
          end
        end
        WC_SETTLE: begin
          balance <= balance_settled;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/wager_controller.md
# wager_controller

Round-level controller for the baccarat table. It owns the player's balance register and sequences each round through betting, wager lock, dealing and settlement. It hands the deal off to the card state machine and pays out from that machine's `result`. It drives `betting`, `load_wager` and `balance` to the datapath and to the top-level LED logic.

## Interface
- `WIDTH`, 8, width of wager and balance.
- `INIT_BALANCE`, 8'd100, balance loaded on reset.
- `TIE_PAYOUT`, 8, tie-bet payout multiple (N:1).

Ports:
- `slow_clock`  in  1  sole clock; all state changes on its rising edge.
- `resetb`  in  1  asynchronous, active-low reset.
- `wager_in`  in  WIDTH  requested wager, sampled in BET.
- `bet_in`  in  2  bet choice: 01 player, 10 dealer, 11 tie, 00 invalid.
- `round_done`  in  1  card state machine has finished the deal and `result` is valid.
- `result`  in  2  outcome: 01 player win, 10 dealer win, 11 tie, 00 none.
- `betting`  out  1  high while in BET.
- `load_wager`  out  1  one-cycle pulse; datapath latches `wager_in`/`bet_in`.
- `start_deal`  out  1  one-cycle pulse; card state machine begins dealing.
- `balance`  out  WIDTH  current registered balance.
- `reject`  out  1  last BET-cycle attempt was invalid.
- `broke`  out  1  balance reached zero; game over.

## Operation
- States: BET, LOCK, DEAL, SETTLE, SHOW, BROKE.
- BET:
  - `betting`=1.
  - Each edge, the attempt is valid iff `bet_in`≠00, `wager_in`≠0 and `wager_in`≤`balance`.
  - Valid attempt: go to LOCK and clear `reject`.
  - Invalid attempt: stay in BET and set `reject`=1.
- LOCK:
  - `load_wager`=1 for this cycle only.
  - Escrow the wager internally (`wager_q`, `bet_q`) and set `balance` ← `balance` − `wager_q`.
  - Next state is always DEAL.
- DEAL:
  - `start_deal`=1 on the first DEAL cycle only.
  - Stay in DEAL until `round_done`=1, then latch `result` into `result_q` and go to SETTLE.
  - `round_done` is ignored in every other state.
- SETTLE: credit the payout to `balance` in one cycle, then go to SHOW. Credit rules:
  - `bet_q`==`result_q` on 01/10: credit 2·W.
  - Tie bet with tie result: credit (`TIE_PAYOUT`+1)·W.
  - `result_q`=11 with a non-tie bet: push, credit W.
  - Any other combination: credit 0.
  - `result_q`=00: treat as a push, credit W.
- SHOW: hold `balance` for one edge. If `balance`==0 go to BROKE, else go to BET.
- BROKE:
  - `broke`=1, `betting`=0.
  - Absorbing; only `resetb` exits.
- Arithmetic:
  - Credit computed in WIDTH+4 bits.
  - `balance` + credit saturates at 2^WIDTH−1.
  - Subtraction in LOCK cannot underflow, because validity is checked in BET.

## Timing
- Reset values:
  - State = BET, `balance`=`INIT_BALANCE`.
  - `betting`=1, `load_wager`=0, `start_deal`=0, `reject`=0, `broke`=0.
  - Escrow registers = 0.
- Latency, valid bet to deal: BET edge → LOCK (1 cycle) → `start_deal` in the next cycle.
- Latency, `round_done` to balance: `round_done` sampled high → updated `balance` visible 1 edge later (end of SETTLE).
- Minimum round is 5 edges: BET, LOCK, DEAL, SETTLE, SHOW.
- `betting`, `broke` and `balance` are registered-state decodes and change only on edges.
- `load_wager` and `start_deal` are Moore outputs, never asserted together.
- `round_done` already high on DEAL entry: `start_deal` still pulses, and SETTLE follows on the next edge.
- Reset asserted in any state, including mid-DEAL, immediately:
  - Restores `INIT_BALANCE`.
  - Discards the escrowed wager.
  - Drops any pulse.

## Structure
- Shared package `baccarat_pkg`, holding the definitions reused by the card state machine and the datapath:
  - `bet_t` enum: BET_NONE, BET_PLAYER, BET_DEALER, BET_TIE.
  - `result_t` enum: RES_NONE, RES_PLAYER, RES_DEALER, RES_TIE.
  - `wc_state_t` enum.
- Sub-module `payout_calc`: purely combinational (`bet_q`, `result_q`, `wager_q`) → credit. It is instantiated once and unit-tested separately.

## Test plan
- Reset, then release with `INIT_BALANCE`=100: `balance`=100, `betting`=1, `broke`=0, no pulses for 3 idle edges with `bet_in`=00.
- Player win: wager 30, bet 01. Expect `load_wager` pulse and `balance`=70 after LOCK, then `start_deal` pulse. Drive `round_done` with `result`=01: `balance`=130 after SETTLE, then `betting`=1.
- Tie bet, saturating: from 100, wager 20, bet 11, `result`=11. `balance` goes 80, then 80+180 saturates to 255.
- Rejects from `balance`=100:
  - Wager 120 → `reject`=1.
  - Bet 00 → `reject`=1.
  - Wager 0 → `reject`=1.
  - In all three cases: no `load_wager`, `balance` stays 100, state stays BET. A following valid wager 10 clears `reject`.
- Push: wager 40, bet 01, `result`=11 → `balance` 60 then 100.
- Bust and reset:
  - Wager 100, bet 10, `result`=01 → `balance`=0, then `broke`=1 and `betting`=0.
  - Further bets are ignored. Asserting `resetb` returns `balance` to 100.
  - Separately, asserting `resetb` mid-DEAL restores 100 with no pulse.
